// File: rtl/multi_edge_pulse_gen_if.sv
// Channel-facing bus of multi_edge_pulse_gen: level inputs, per-channel edge
// mode, overrun clear, and the pulse/overrun outputs.
interface multi_edge_pulse_gen_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]   LVL_SIG;
  logic [2*NUM_CH-1:0] EDGE_MODE;
  logic [NUM_CH-1:0]   CLR_OVR;
  logic [NUM_CH-1:0]   PULSE_SIG;
  logic [NUM_CH-1:0]   OVR;
  logic                ANY_PULSE;

  modport master (
    output LVL_SIG, EDGE_MODE, CLR_OVR,
    input  PULSE_SIG, OVR, ANY_PULSE
  );

  modport slave (
    input  LVL_SIG, EDGE_MODE, CLR_OVR,
    output PULSE_SIG, OVR, ANY_PULSE
  );
endinterface

// File: rtl/multi_edge_pulse_gen.sv
// Multi-channel edge-to-pulse generator. Each channel synchronises an async
// level, detects rise/fall/both edges and emits a PULSE_W-cycle pulse.
// Optional macro PULSE_GEN_RETRIG_EN: channels become retriggerable and the
// overrun flags are removed (OVR tied to 0). Default: non-retriggerable with
// sticky overrun flags.

module multi_edge_pulse_gen_ch #(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_W     = 1,
  parameter int CNT_W       = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       lvl,
  input  logic [1:0] mode,
  input  logic       clr_ovr,
  output logic       pulse,
  output logic       ovr
);
  localparam logic [CNT_W-1:0] PW  = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   h;
  logic                   s, rise, fall, edge_det;
  logic [CNT_W-1:0]       cnt, cnt_nxt;

  assign s        = sync_pipe[SYNC_STAGES-1];
  assign rise     = s & ~h;
  assign fall     = ~s & h;
  assign edge_det = (mode[0] & rise) | (mode[1] & fall);
  assign pulse    = (cnt != '0);

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_pipe <= '0;
      h         <= 1'b0;
    end else begin
      sync_pipe[0] <= lvl;
      for (int j = 1; j < SYNC_STAGES; j++) sync_pipe[j] <= sync_pipe[j-1];
      h <= s;
    end
  end

  // Pulse counter register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt <= '0;
    else      cnt <= cnt_nxt;
  end

`ifdef PULSE_GEN_RETRIG_EN
  // Counter next state: any edge reloads, stretching the pulse past the latest edge.
  always_comb begin
    cnt_nxt = cnt;
    if (mode == 2'b00)   cnt_nxt = '0;
    else if (edge_det)   cnt_nxt = PW;
    else if (cnt != '0)  cnt_nxt = cnt - ONE;
  end

  logic unused_clr;
  assign unused_clr = clr_ovr;
  assign ovr        = 1'b0;
`else
  logic ovr_set, ovr_q;

  // Counter next state: an edge in the final pulse cycle (or idle) is accepted,
  // so back-to-back pulses merge; an earlier edge is dropped and flagged.
  always_comb begin
    cnt_nxt = cnt;
    ovr_set = 1'b0;
    if (mode == 2'b00) begin
      cnt_nxt = '0;
    end else if (edge_det && cnt <= ONE) begin
      cnt_nxt = PW;
    end else if (edge_det) begin
      cnt_nxt = cnt - ONE;
      ovr_set = 1'b1;
    end else if (cnt != '0) begin
      cnt_nxt = cnt - ONE;
    end
  end

  // Sticky overrun flag; a set in the same cycle as a clear wins.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ovr_q <= 1'b0;
    else      ovr_q <= ovr_set | (ovr_q & ~clr_ovr);
  end

  assign ovr = ovr_q;
`endif
endmodule

module multi_edge_pulse_gen #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_W     = 1,
  parameter int CNT_W       = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  multi_edge_pulse_gen_if.slave bus
);
  if ((2 ** CNT_W) <= PULSE_W) begin : g_bad_cnt_w
    $error("CNT_W too narrow for PULSE_W");
  end

  logic [NUM_CH-1:0] pulse_v, ovr_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    multi_edge_pulse_gen_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .PULSE_W     (PULSE_W),
      .CNT_W       (CNT_W)
    ) u_ch (
      .CLK     (CLK),
      .RST     (RST),
      .lvl     (bus.LVL_SIG[i]),
      .mode    (bus.EDGE_MODE[2*i+1:2*i]),
      .clr_ovr (bus.CLR_OVR[i]),
      .pulse   (pulse_v[i]),
      .ovr     (ovr_v[i])
    );
  end

  assign bus.PULSE_SIG = pulse_v;
  assign bus.OVR       = ovr_v;
  assign bus.ANY_PULSE = |pulse_v;
endmodule

// File: tb/tb_multi_edge_pulse_gen.sv
// Scoreboard bench: stimulus pushes cycle-tagged expectations for two DUTs
// (PULSE_W=1 and PULSE_W=5); a negedge monitor pops and compares them.
module tb_multi_edge_pulse_gen;
`ifdef PULSE_GEN_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif
  localparam logic [3:0] OVR0 = RETRIG ? 4'h0 : 4'h1;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  multi_edge_pulse_gen_if #(.NUM_CH(4)) if1 ();
  multi_edge_pulse_gen_if #(.NUM_CH(4)) if5 ();

  multi_edge_pulse_gen #(.NUM_CH(4), .SYNC_STAGES(2), .PULSE_W(1), .CNT_W(8))
    u1 (.CLK(CLK), .RST(RST), .bus(if1.slave));
  multi_edge_pulse_gen #(.NUM_CH(4), .SYNC_STAGES(2), .PULSE_W(5), .CNT_W(8))
    u5 (.CLK(CLK), .RST(RST), .bus(if5.slave));

  typedef struct {
    int         c;
    int         dut;
    logic [3:0] p;
    logic [3:0] o;
  } exp_t;
  exp_t q[$];

  task automatic push(input int c, input int dut, input logic [3:0] p, input logic [3:0] o);
    exp_t e;
    e.c = c; e.dut = dut; e.p = p; e.o = o;
    q.push_back(e);
  endtask

  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitor: compare every expectation due at this cycle.
  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].c <= cyc) begin
      exp_t e;
      logic [3:0] ap, ao;
      logic       aa;
      e  = q.pop_front();
      ap = (e.dut == 1) ? if1.PULSE_SIG : if5.PULSE_SIG;
      ao = (e.dut == 1) ? if1.OVR       : if5.OVR;
      aa = (e.dut == 1) ? if1.ANY_PULSE : if5.ANY_PULSE;
      n_tests++;
      if (e.c < cyc) begin
        n_fail++;
        $display("FAIL missed_check u%0d cyc=%0d now=%0d", e.dut, e.c, cyc);
      end else if (ap !== e.p || ao !== e.o || aa !== (|e.p)) begin
        n_fail++;
        $display("FAIL u%0d cyc=%0d pulse=%b exp=%b ovr=%b exp=%b any=%b exp=%b",
                 e.dut, cyc, ap, e.p, ao, e.o, aa, |e.p);
      end
    end
  end

  initial begin
    if1.LVL_SIG = 4'hF; if1.EDGE_MODE = 8'h55; if1.CLR_OVR = 4'h0;
    if5.LVL_SIG = 4'h0; if5.EDGE_MODE = 8'h55; if5.CLR_OVR = 4'h0;

    // Reset state, then release with all LVL_SIG high on u1 (mode rise).
    push(1, 1, 4'h0, 4'h0);
    push(2, 5, 4'h0, 4'h0);
    go(3);
    push(3, 1, 4'h0, 4'h0);
    push(5, 1, 4'h0, 4'h0);
    push(6, 1, 4'hF, 4'h0);
    push(6, 5, 4'h0, 4'h0);
    push(7, 1, 4'h0, 4'h0);
    RST = 1'b1;

    // Edge modes: ch0 rise, ch1 fall, ch2 both, ch3 off.
    go(10);
    push(12, 1, 4'h0, 4'h0);
    push(13, 1, 4'h6, 4'h0);
    push(14, 1, 4'h0, 4'h0);
    if1.EDGE_MODE = 8'h39; if1.LVL_SIG = 4'h0;
    go(20);
    push(22, 1, 4'h0, 4'h0);
    push(23, 1, 4'h5, 4'h0);
    push(24, 1, 4'h0, 4'h0);
    if1.LVL_SIG = 4'hF;
    go(30);
    push(33, 1, 4'h6, 4'h0);
    push(34, 1, 4'h0, 4'h0);
    if1.LVL_SIG = 4'h0;

    // PULSE_W=1, toggle every cycle in mode both: continuous high, no overrun.
    go(40);
    if1.EDGE_MODE = 8'hFF;
    push(43, 1, 4'h0, 4'h0);
    push(44, 1, 4'h1, 4'h0);
    push(47, 1, 4'h1, 4'h0);
    push(51, 1, 4'h1, 4'h0);
    push(52, 1, 4'h0, 4'h0);
    for (int n = 41; n <= 48; n++) begin
      go(n);
      if1.LVL_SIG[0] = ~if1.LVL_SIG[0];
    end

    // PULSE_W=5 overrun: toggles at 60 and 62 on ch0 (mode both).
    go(60);
    if5.EDGE_MODE = 8'h03;
    push(62, 5, 4'h0, 4'h0);
    push(63, 5, 4'h1, 4'h0);
    push(64, 5, 4'h1, 4'h0);
    push(65, 5, 4'h1, OVR0);
    push(67, 5, 4'h1, OVR0);
    push(68, 5, RETRIG ? 4'h1 : 4'h0, OVR0);
    push(69, 5, RETRIG ? 4'h1 : 4'h0, OVR0);
    push(70, 5, 4'h0, OVR0);
    push(71, 5, 4'h0, 4'h0);
    if5.LVL_SIG[0] = 1'b1;
    go(62);
    if5.LVL_SIG[0] = 1'b0;
    go(70);
    if5.CLR_OVR[0] = 1'b1;
    go(71);
    if5.CLR_OVR[0] = 1'b0;

    // Overrun coinciding with CLR_OVR: the set wins.
    go(75);
    push(78, 5, 4'h1, 4'h0);
    push(79, 5, 4'h1, 4'h0);
    push(80, 5, 4'h1, OVR0);
    push(81, 5, 4'h1, OVR0);
    push(83, 5, RETRIG ? 4'h1 : 4'h0, OVR0);
    if5.LVL_SIG[0] = 1'b1;
    go(77);
    if5.LVL_SIG[0] = 1'b0;
    go(79);
    if5.CLR_OVR[0] = 1'b1;
    go(80);
    if5.CLR_OVR[0] = 1'b0;

    // Back-to-back: second edge lands in the last pulse cycle -> 10-cycle high.
    go(90);
    push(92, 5, 4'h0, OVR0);
    push(93, 5, 4'h1, OVR0);
    push(97, 5, 4'h1, OVR0);
    push(98, 5, 4'h1, OVR0);
    push(102, 5, 4'h1, OVR0);
    push(103, 5, 4'h0, OVR0);
    if5.LVL_SIG[0] = 1'b1;
    go(95);
    if5.LVL_SIG[0] = 1'b0;

    // Disable mid-pulse at pulse cycle 3: low at the next clock.
    go(110);
    push(113, 5, 4'h1, OVR0);
    push(115, 5, 4'h1, OVR0);
    push(116, 5, 4'h0, OVR0);
    push(118, 5, 4'h0, OVR0);
    if5.LVL_SIG[0] = 1'b1;
    go(115);
    if5.EDGE_MODE = 8'h00;
    go(118);
    if5.EDGE_MODE = 8'h03;

    // Reset mid-pulse at pulse cycle 4: outputs clear without a clock edge.
    go(125);
    push(128, 5, 4'h1, OVR0);
    push(130, 5, 4'h1, OVR0);
    push(131, 5, 4'h0, 4'h0);
    push(131, 1, 4'h0, 4'h0);
    push(137, 5, 4'h0, 4'h0);
    push(137, 1, 4'h0, 4'h0);
    if5.LVL_SIG[0] = 1'b0;
    go(131);
    RST = 1'b0;
    go(134);
    RST = 1'b1;

    // Drain the scoreboard with a bounded wait.
    go(140);
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge CLK);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
